// File: rtl/matrix_vector_pkg.sv
// Shared types and helpers for the time-multiplexed matrix-vector scheduler.
package matrix_vector_pkg;

  typedef enum logic [1:0] {IDLE, GET_ROW, MAC, OUT} state_t;

  localparam int MAX_VEC_W = 1024;
  localparam int MAX_DW    = 32;

  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n + 1);
  endfunction

  // Element idx of a packed vector whose elements are dw bits wide.
  function automatic logic [MAX_DW-1:0] get_elem(input logic [MAX_VEC_W-1:0] vec,
                                                 input int idx, input int dw);
    logic [MAX_VEC_W-1:0] shifted;
    logic [MAX_DW-1:0]    mask;
    shifted = vec >> (idx * dw);
    mask    = (MAX_DW'(1) << dw) - MAX_DW'(1);
    return shifted[MAX_DW-1:0] & mask;
  endfunction

endpackage

// File: rtl/matrix_vector_scheduler_mac.sv
// Single multiply-accumulate lane: clear restarts the sum, enable adds a*b.
module mac_unit #(
  parameter int DW    = 8,
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DW-1:0]    a,
  input  logic [DW-1:0]    b,
  output logic [ACC_W-1:0] acc
);

  logic [2*DW-1:0] product;

  assign product = (2 * DW)'(a) * (2 * DW)'(b);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(product);
    end
  end

endmodule

// File: rtl/matrix_vector_scheduler.sv
// Streams one vector then M rows through a single MAC lane, emitting one
// dot product per row on a valid/ready result port.
module matrix_vector_scheduler
  import matrix_vector_pkg::*;
#(
  parameter  int M     = 4,
  parameter  int N     = 4,
  parameter  int DW    = 8,
  localparam int ACC_W = acc_width(N, DW),
  localparam int RW    = (M > 1) ? $clog2(M) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vec_valid,
  output logic              vec_ready,
  input  logic [N*DW-1:0]   vec_data,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic [N*DW-1:0]   row_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic [RW-1:0]     res_row,
  output logic              res_last,
  output logic              busy,
  output logic              done
);

  localparam int          KW     = $clog2(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);
  localparam logic [RW-1:0] R_LAST = RW'(M - 1);

  state_t          state_reg;
  logic [N*DW-1:0] vec_reg;
  logic [N*DW-1:0] row_reg;
  logic [RW-1:0]   r_reg;
  logic [KW-1:0]   k_reg;

  logic [DW-1:0]   vec_elem [N];
  logic [DW-1:0]   row_elem [N];
  logic            mac_clear;
  logic            mac_en;
  logic [ACC_W-1:0] acc;

  for (genvar gi = 0; gi < N; gi++) begin : g_elem
    assign vec_elem[gi] = DW'(get_elem(MAX_VEC_W'(vec_reg), gi, DW));
    assign row_elem[gi] = DW'(get_elem(MAX_VEC_W'(row_reg), gi, DW));
  end

  assign mac_clear = (state_reg == GET_ROW) && row_valid;
  assign mac_en    = (state_reg == MAC);

  mac_unit #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clear  (mac_clear),
    .enable (mac_en),
    .a      (row_elem[k_reg]),
    .b      (vec_elem[k_reg]),
    .acc    (acc)
  );

  // The accumulator is frozen outside MAC, so it doubles as the result register.
  assign res_data = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      vec_reg   <= '0;
      row_reg   <= '0;
      r_reg     <= '0;
      k_reg     <= '0;
      vec_ready <= 1'b1;
      row_ready <= 1'b0;
      res_valid <= 1'b0;
      res_row   <= '0;
      res_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (vec_valid) begin
            vec_reg   <= vec_data;
            r_reg     <= '0;
            vec_ready <= 1'b0;
            row_ready <= 1'b1;
            busy      <= 1'b1;
            state_reg <= GET_ROW;
          end
        end
        GET_ROW: begin
          if (row_valid) begin
            row_reg   <= row_data;
            k_reg     <= '0;
            row_ready <= 1'b0;
            state_reg <= MAC;
          end
        end
        MAC: begin
          k_reg <= k_reg + 1'b1;
          if (k_reg == K_LAST) begin
            res_valid <= 1'b1;
            res_row   <= r_reg;
            res_last  <= (r_reg == R_LAST);
            state_reg <= OUT;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            if (r_reg == R_LAST) begin
              done      <= 1'b1;
              busy      <= 1'b0;
              vec_ready <= 1'b1;
              state_reg <= IDLE;
            end else begin
              r_reg     <= r_reg + 1'b1;
              row_ready <= 1'b1;
              state_reg <= GET_ROW;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_vector_scheduler.sv
// Scoreboard bench: stimulus pushes expected dot products, a monitor pops and
// compares them on every result handshake, plus protocol and timing checks.
module tb_matrix_vector_scheduler;

  localparam int M       = 4;
  localparam int N       = 4;
  localparam int DW      = 8;
  localparam int ACC_W   = 2 * DW + $clog2(N + 1);
  localparam int RW      = (M > 1) ? $clog2(M) : 1;
  localparam int TIMEOUT = 500;

  logic             clk = 1'b0;
  logic             rst;
  logic             vec_valid;
  logic             vec_ready;
  logic [N*DW-1:0]  vec_data;
  logic             row_valid;
  logic             row_ready;
  logic [N*DW-1:0]  row_data;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic [RW-1:0]    res_row;
  logic             res_last;
  logic             busy;
  logic             done;

  matrix_vector_scheduler #(.M(M), .N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .vec_data  (vec_data),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_row   (res_row),
    .res_last  (res_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint data;
    int     row;
    bit     last;
  } exp_t;

  exp_t            exp_q [$];
  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  int              ready_mode = 0;
  int              hold_cnt   = 0;
  bit              fast_mode  = 0;
  logic [N*DW-1:0] row_buf [M];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference: plain sum of element products.
  function automatic longint dot(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b);
    longint s = 0;
    for (int j = 0; j < N; j++) s += longint'(a[j*DW +: DW]) * longint'(b[j*DW +: DW]);
    return s;
  endfunction

  function automatic logic [N*DW-1:0] rand_word();
    logic [N*DW-1:0] w;
    for (int j = 0; j < N; j++) w[j*DW +: DW] = DW'($urandom_range(0, (1 << DW) - 1));
    return w;
  endfunction

  // All tasks start and end at posedge+1.
  task automatic send_vec(input logic [N*DW-1:0] v);
    int waited = 0;
    vec_data  = v;
    vec_valid = 1'b1;
    @(negedge clk);
    while (!vec_ready) begin
      waited++;
      if (waited > TIMEOUT) begin check("vec_accept_timeout", 1, 0); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    vec_valid = 1'b0;
    vec_data  = rand_word();
  endtask

  task automatic send_row(input logic [N*DW-1:0] d);
    int waited = 0;
    row_data  = d;
    row_valid = 1'b1;
    @(negedge clk);
    while (!row_ready) begin
      waited++;
      if (waited > TIMEOUT) begin check("row_accept_timeout", 1, 0); break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
    row_valid = 1'b0;
  endtask

  task automatic run_pass(input logic [N*DW-1:0] v, input int max_gap);
    exp_t e;
    for (int r = 0; r < M; r++) begin
      e.data = dot(row_buf[r], v);
      e.row  = r;
      e.last = (r == M - 1);
      exp_q.push_back(e);
    end
    send_vec(v);
    for (int r = 0; r < M; r++) begin
      int gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      for (int g = 0; g < gap; g++) begin
        vec_valid = 1'($urandom_range(0, 1));
        vec_data  = rand_word();
        @(posedge clk); #1;
      end
      vec_valid = 1'b0;
      send_row(row_buf[r]);
    end
  endtask

  task automatic drain();
    int w = 0;
    @(posedge clk); #1;
    while ((exp_q.size() != 0 || busy) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 2000) check("drain_timeout", 1, 0);
  endtask

  // Result-ready driver.
  initial begin
    res_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: res_ready = 1'b1;
        1: res_ready = 1'($urandom_range(0, 1));
        default: begin
          if (res_valid && res_row == RW'(1) && hold_cnt < 7) begin
            res_ready = 1'b0;
            hold_cnt++;
          end else begin
            res_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor state.
  bit               mon_prev_stall;
  bit               mon_prev_valid;
  bit               mon_pending_done;
  int               mon_row_hs;
  int               mon_last_hs;
  logic [ACC_W-1:0] mon_held_data;
  logic [RW-1:0]    mon_held_row;
  logic             mon_held_last;

  initial begin
    exp_t e;
    mon_prev_stall = 0; mon_prev_valid = 0; mon_pending_done = 0;
    mon_row_hs = -1; mon_last_hs = -1;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        mon_prev_stall = 0; mon_prev_valid = 0; mon_pending_done = 0;
        mon_row_hs = -1; mon_last_hs = -1;
        continue;
      end
      check("done_pulse", done, mon_pending_done);
      if (mon_pending_done) check("busy_after_done", busy, 0);
      mon_pending_done = 0;
      check("ready_exclusive", vec_ready & row_ready, 0);
      check("vec_ready_vs_busy", vec_ready, !busy);
      if (res_valid) check("row_ready_during_out", row_ready, 0);
      if (mon_prev_stall) begin
        check("stall_valid", res_valid, 1);
        check("stall_data", res_data, mon_held_data);
        check("stall_row", res_row, mon_held_row);
        check("stall_last", res_last, mon_held_last);
      end
      if (res_valid && !mon_prev_valid && mon_row_hs >= 0)
        check("latency", cyc - mon_row_hs, N + 1);
      if (row_valid && row_ready) mon_row_hs = cyc;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_row", res_row, e.row);
          check("res_last", res_last, e.last);
          if (e.last) mon_pending_done = 1;
          if (fast_mode && e.row != 0 && mon_last_hs >= 0)
            check("throughput", cyc - mon_last_hs, N + 2);
          $display("result row %0d data %0d expected %0d", res_row, res_data, e.data);
        end
        mon_last_hs = cyc;
      end
      mon_prev_stall = res_valid && !res_ready;
      mon_prev_valid = res_valid;
      mon_held_data  = res_data;
      mon_held_row   = res_row;
      mon_held_last  = res_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*DW-1:0] v;
    rst = 1'b1; vec_valid = 1'b0; vec_data = '0; row_valid = 1'b0; row_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vec_ready", vec_ready, 1);
    check("rst_row_ready", row_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_row", res_row, 0);
    check("rst_res_last", res_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Rows offered in IDLE must be ignored.
    row_valid = 1'b1; row_data = rand_word();
    repeat (5) @(posedge clk);
    #1;
    row_valid = 1'b0;
    check("idle_row_ignored_busy", busy, 0);
    check("idle_row_ignored_ready", vec_ready, 1);

    // Directed pass, full throughput.
    ready_mode = 0; fast_mode = 1;
    row_buf[0] = {8'd1, 8'd1, 8'd1, 8'd1};
    row_buf[1] = {8'd0, 8'd0, 8'd0, 8'd2};
    row_buf[2] = {8'd255, 8'd0, 8'd0, 8'd0};
    row_buf[3] = {8'd255, 8'd255, 8'd255, 8'd255};
    run_pass({8'd4, 8'd3, 8'd2, 8'd1}, 0);
    drain();
    fast_mode = 0;

    // Backpressure on row 1.
    ready_mode = 2; hold_cnt = 0;
    run_pass({8'd4, 8'd3, 8'd2, 8'd1}, 0);
    drain();

    // Maximum operands.
    ready_mode = 0;
    for (int r = 0; r < M; r++) row_buf[r] = '1;
    run_pass('1, 0);
    drain();

    // Reset during MAC cycle 2 of row 2.
    for (int r = 0; r < M; r++) row_buf[r] = rand_word();
    v = rand_word();
    for (int r = 0; r < M; r++) begin
      exp_t e;
      e.data = dot(row_buf[r], v); e.row = r; e.last = (r == M - 1);
      exp_q.push_back(e);
    end
    send_vec(v);
    send_row(row_buf[0]);
    send_row(row_buf[1]);
    send_row(row_buf[2]);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_vec_ready", vec_ready, 1);
    check("midrst_done", done, 0);
    repeat (3) @(posedge clk);
    #1;

    // Fresh pass after the abort.
    for (int r = 0; r < M; r++) row_buf[r] = rand_word();
    run_pass(rand_word(), 0);
    drain();

    // Randomized passes with random gaps, noise and backpressure.
    ready_mode = 1;
    for (int p = 0; p < 15; p++) begin
      for (int r = 0; r < M; r++) row_buf[r] = rand_word();
      run_pass(rand_word(), 3);
    end
    drain();

    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_vector_scheduler.md
Name: matrix_vector_scheduler

Overview:
- Sequencing controller for a time-multiplexed matrix-times-vector computation. It uses one multiply-accumulate (MAC) lane instead of M*N parallel multipliers.
- Accepts one vector per pass, then M matrix rows over a valid/ready stream. Each row's dot product is computed over N cycles.
- Results are emitted per row on a valid/ready output stream.
- Sits between a matrix/vector source (memory or test driver) and a result consumer. It is the low-area alternative to the combinational matrix_mult_vector datapath, with the same M/N/DW parameterisation.

Parameters:
- M, 4, number of matrix rows (results per pass); M >= 1.
- N, 4, number of columns = vector length; N >= 2.
- DW, 8, unsigned element width.
- ACC_W, 2*DW + $clog2(N+1), result width (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- vec_valid  input  1  vector word available.
- vec_ready  output  1  scheduler can accept a vector.
- vec_data  input  N*DW  vector; element j at [j*DW +: DW].
- row_valid  input  1  matrix row available.
- row_ready  output  1  scheduler can accept a row.
- row_data  input  N*DW  matrix row; element j at [j*DW +: DW].
- res_valid  output  1  result valid.
- res_ready  input  1  consumer accepts result.
- res_data  output  ACC_W  unsigned dot product for the current row.
- res_row  output  $clog2(M) (min 1)  row index of res_data.
- res_last  output  1  res_data belongs to row M-1.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse on the handshake of the last result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. rst has priority over all other inputs in the same cycle.
- Reset values: state=IDLE, vec_ready=1, row_ready=0, res_valid=0, res_data=0, res_row=0, res_last=0, busy=0, done=0. Internal row counter, element counter, accumulator and latched vector/row are all cleared.
- FSM states:
  - IDLE: vec_ready=1. On vec_valid, latch vec_data, set row counter r=0, go to GET_ROW.
  - GET_ROW: row_ready=1. On row_valid, latch row_data, clear acc, set element counter k=0, go to MAC.
  - MAC: each cycle acc <= acc + row[k]*vec[k] and k++. After the k=N-1 accumulate, go to OUT. MAC lasts exactly N cycles.
  - OUT: res_valid=1, res_data=acc, res_row=r, res_last=(r==M-1).
    - On res_ready with r<M-1: r++, go to GET_ROW.
    - On res_ready with r==M-1: pulse done, go to IDLE.
- Latency: the row handshake happens in cycle t. res_valid rises in cycle t+N+1.
- Handshake rules:
  - A transfer occurs only when valid&&ready are both high at a rising edge.
  - vec_ready and row_ready depend only on state, never combinationally on valid.
  - res_valid, res_data, res_row and res_last stay stable while res_valid=1 and res_ready=0. res_valid does not drop without a handshake.
  - Only one of vec_ready and row_ready is high at a time.
  - The vector is reused for all M rows and is not reloaded mid-pass.
- Arithmetic: unsigned multiply at 2*DW bits, zero-extended to ACC_W; no overflow is possible. Worst case for the defaults: 4*255*255=260100 < 2^19.
- Boundary conditions:
  - A row presented while in IDLE is ignored (row_ready=0).
  - vec_valid asserted mid-pass is ignored until the return to IDLE.
  - res_ready high while res_valid=0 has no effect.
  - Back-to-back best case is one row every N+2 cycles: GET_ROW, N MAC cycles, OUT with res_ready=1.
  - rst mid-MAC or mid-OUT drops res_valid next cycle and discards partial results. No done pulse is generated.
  - M=1: the first result has res_last=1 and done follows its handshake.

Decomposition:
- Package matrix_vector_pkg contains:
  - state enum {IDLE, GET_ROW, MAC, OUT};
  - function acc_width(N, DW);
  - function for element extraction from a packed vector.
- Optional sub-module mac_unit (DW, ACC_W): clear, enable, a, b -> acc, registered accumulate. Counters and FSM stay in the top level.

Test Plan:
- Reset/idle: hold rst for 3 cycles -> all outputs at reset values, vec_ready=1, busy=0. Assert row_valid in IDLE -> never accepted.
- Single pass, defaults: vec={4,3,2,1} (element0=1), rows r0={1,1,1,1}, r1={2,0,0,0}, r2={0,0,0,255}, r3={255,255,255,255}, res_ready=1 -> res_data 10, 2, 1020, 2550 with res_row 0..3. res_last only on row 3, done pulses once, busy falls the next cycle.
- Latency: row handshake at cycle t -> res_valid at t+5 for N=4, steady throughput one result per 6 cycles.
- Backpressure: hold res_ready=0 for 7 cycles on row 1 -> res_data=2 and res_row=1 stable throughout, row_ready=0, then resume correctly.
- Max value: all vec and row elements = 255 -> every result 260100, no truncation.
- Reset mid-operation: assert rst during MAC cycle 2 of row 2 -> next cycle IDLE, res_valid=0, no done. A fresh pass then produces correct results from row 0.
